// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// ALU control codes, the FSM state type and the request decode.
package muldiv_sequencer_pkg;

  // ALU control codes seen on alu_ctrl; only MULT and DIV start work here.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_MULT = 4'd7;
  localparam logic [3:0] ALU_DIV  = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  // True for the control codes this block executes.
  function automatic logic is_muldiv(input logic [3:0] code);
    return (code == ALU_MULT) || (code == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// is non-negative and report that as the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; the sign of the difference decides the quotient bit.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide unit. Works on operand magnitudes one
// bit per cycle (shift-add multiply, restoring divide), fixes the signs in a
// single cycle and presents {hi,lo} with a one-cycle done pulse.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] mag_a;     // |op_a|; shifted out MSB-first while dividing
  logic [WIDTH-1:0] mag_b;     // |op_b|; shifted out LSB-first while multiplying
  logic [WIDTH-1:0] acc_hi;    // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo;    // product lower half / quotient
  logic [CNT_W-1:0] cnt;
  logic             op_div;
  logic             sign_a;
  logic             neg_res;
  logic             b_zero;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] hi_fix;
  logic [WIDTH-1:0] lo_fix;

  // Gated by rst_n so stall stays low while reset is held.
  assign accept    = rst_n && start && (state == IDLE) && is_muldiv(alu_ctrl);
  assign last_iter = (cnt == LAST);
  // Combinational so the issuing instruction is held in its own cycle.
  assign stall     = busy | accept;

  // Shift-add step: add the multiplicand when the current multiplier bit is
  // set, then shift the (WIDTH+1)-bit sum right into the product pair.
  assign mul_sum = {1'b0, acc_hi} + {1'b0, {WIDTH{mag_b[0]}} & mag_a};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (acc_hi),
    .dividend_bit (mag_a[WIDTH-1]),
    .divisor      (mag_b),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode plus busy/done, which depend only on the state.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (accept) state_next = (alu_ctrl == ALU_MULT) ? MUL : DIV;
      MUL: begin
        busy = 1'b1;
        if (last_iter) state_next = FIX;
      end
      DIV: begin
        busy = 1'b1;
        // A zero divisor spends one cycle here and skips the iterations.
        if (b_zero || last_iter) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sign correction of the magnitude results; a zero divisor yields
  // quotient all-ones and remainder = the original dividend.
  always_comb begin
    prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (op_div) begin
      if (b_zero) begin
        lo_fix = '1;
        hi_fix = sign_a ? -mag_a : mag_a;
      end else begin
        lo_fix = neg_res ? -acc_lo : acc_lo;
        hi_fix = sign_a ? -acc_hi : acc_hi;
      end
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a       <= '0;
      mag_b       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      cnt         <= '0;
      op_div      <= 1'b0;
      sign_a      <= 1'b0;
      neg_res     <= 1'b0;
      b_zero      <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mag_a       <= op_a[WIDTH-1] ? -op_a : op_a;
          mag_b       <= op_b[WIDTH-1] ? -op_b : op_b;
          sign_a      <= op_a[WIDTH-1];
          neg_res     <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
          op_div      <= (alu_ctrl == ALU_DIV);
          b_zero      <= (op_b == '0);
          cnt         <= '0;
          acc_hi      <= '0;
          acc_lo      <= '0;
          div_by_zero <= 1'b0;
        end
        MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          mag_b  <= mag_b >> 1;
          cnt    <= cnt + 1'b1;
        end
        DIV: if (!b_zero) begin
          acc_hi <= rem_next;
          acc_lo <= {acc_lo[WIDTH-2:0], q_bit};
          mag_a  <= mag_a << 1;
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          hi          <= hi_fix;
          lo          <= lo_fix;
          div_by_zero <= op_div & b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (WIDTH=32): latency, results, sign
// handling, divide-by-zero, ignored requests, held start and mid-op reset.
module tb_muldiv_sequencer;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       alu_ctrl = 4'd0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             busy, stall, done, div_by_zero;
  logic [WIDTH-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  int          lat;
  logic        busy_c1, stall_c1, dbz_c1, busy_pre, busy_at_done, dbz_done;
  logic [31:0] hi_c1, lo_c1, hi_done, lo_done;
  logic [31:0] prev_hi = 32'h0;
  logic [31:0] prev_lo = 32'h0;
  logic        seen;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_ctrl    (alu_ctrl),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request before edge k, then scramble the operands after it.
  task automatic issue(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input bit hold);
    @(negedge clk);
    start = 1'b1; alu_ctrl = ctrl; op_a = a; op_b = b;
    #1 chk({tag, "_stall_on_accept"}, stall, 1);
    @(posedge clk);
    #1;
    op_a = $urandom;
    op_b = $urandom;
    if (!hold) start = 1'b0;
  endtask

  // Count cycles after edge k until done; lat stays -1 if the budget expires.
  task automatic wait_done(input int budget, input bit hold);
    lat = -1; busy_at_done = 1'b1; busy_pre = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) begin
        busy_c1 = busy; stall_c1 = stall; dbz_c1 = div_by_zero;
        hi_c1 = hi; lo_c1 = lo;
      end
      if (done === 1'b1) begin
        lat = c; busy_at_done = busy; dbz_done = div_by_zero;
        hi_done = hi; lo_done = lo;
        if (hold) start = 1'b0;
        break;
      end
      busy_pre = busy;
    end
    start = (hold && lat < 0) ? 1'b0 : start;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz, input bit hold);
    issue(tag, ctrl, a, b, hold);
    wait_done(60, hold);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_first"}, busy_c1, 1);
    chk({tag, "_stall_first"}, stall_c1, 1);
    chk({tag, "_busy_before_done"}, busy_pre, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    chk({tag, "_dbz_cleared"}, dbz_c1, 0);
    chk({tag, "_hilo_held"}, {hi_c1, lo_c1}, {prev_hi, prev_lo});
    chk({tag, "_hi"}, hi_done, exp_hi);
    chk({tag, "_lo"}, lo_done, exp_lo);
    chk({tag, "_dbz"}, dbz_done, exp_dbz);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hilo_hold"}, {hi, lo}, {exp_hi, exp_lo});
    chk({tag, "_dbz_hold"}, div_by_zero, exp_dbz);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    // Reset with a valid request pending: everything must stay zero.
    #3 rst_n = 1'b0;
    start = 1'b1; alu_ctrl = 4'd7;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    start = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    run_op("mul_7_m3", 4'd7, 32'd7, 32'hFFFFFFFD, 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);

    // Unsupported code: no stall, no activity, results untouched.
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'd2; op_a = 32'd9; op_b = 32'd3;
    #1 chk("ign_stall", stall, 0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | busy | done | stall;
    end
    chk("ign_activity", seen, 0);
    chk("ign_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    start = 1'b0;

    run_op("div_m7_2", 4'd8, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("div_100_m7", 4'd8, 32'd100, 32'hFFFFFFF9, 34, 32'd2, 32'hFFFFFFF2, 1'b0, 1'b0);
    run_op("div_m100_7", 4'd8, 32'hFFFFFF9C, 32'd7, 34, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 1'b0);
    run_op("div_min_m1", 4'd8, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 1'b0, 1'b0);
    run_op("mul_max_max", 4'd7, 32'h7FFFFFFF, 32'h7FFFFFFF, 34, 32'h3FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op("div_5_0", 4'd8, 32'd5, 32'd0, 3, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("dbz_sticky", div_by_zero, 1);
    run_op("div_m9_0", 4'd8, 32'hFFFFFFF7, 32'd0, 3, 32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1, 1'b0);
    // The next accepted mult clears the flag (dbz_cleared inside run_op).
    run_op("mul_after_dbz", 4'd7, 32'd3, 32'd4, 34, 32'd0, 32'd12, 1'b0, 1'b0);

    // start held high for the whole operation: exactly one done.
    run_op("mul_hold", 4'd7, 32'd3, 32'd5, 34, 32'd0, 32'd15, 1'b0, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("hold_single_done", seen, 0);

    // Reset ten cycles into a mult: abort with no done pulse.
    issue("mul_abort", 4'd7, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_stall", stall, 0);
    chk("abort_done", done, 0);
    chk("abort_dbz", div_by_zero, 0);
    chk("abort_hilo", {hi, lo}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("abort_no_done", seen, 0);
    prev_hi = 32'h0;
    prev_lo = 32'h0;
    run_op("mul_min_m1", 4'd7, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal values are even and at least 4.
REQ-002 Parameter: CNT_W, default 6, iteration-counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request qualifier, sampled on the rising edge.
REQ-006 Port: alu_ctrl  input  4  ALU control code; 4'd7 = mult, 4'd8 = div, all other codes are ignored.
REQ-007 Port: op_a  input  WIDTH  signed multiplicand or dividend.
REQ-008 Port: op_b  input  WIDTH  signed multiplier or divisor.
REQ-009 Port: busy  output  1  operation in progress.
REQ-010 Port: stall  output  1  pipeline hold request.
REQ-011 Port: done  output  1  one-cycle pulse; hi and lo are valid in this cycle.
REQ-012 Port: div_by_zero  output  1  sticky flag for the last div; cleared at the next accepted operation.
REQ-013 Port: hi  output  WIDTH  product upper half, or remainder for div.
REQ-014 Port: lo  output  WIDTH  product lower half, or quotient for div.

Function
REQ-015 FSM states SHALL be: IDLE, MUL, DIV, FIX, DONE.
REQ-016 Accept rule: an operation is accepted when start=1, state=IDLE and alu_ctrl is 7 or 8; start with any other code, or in any other state, SHALL be ignored with no side effects.
REQ-017 On accept, the block SHALL:
  - register |op_a|, |op_b| and the result sign bits;
  - clear the counter, the accumulators and div_by_zero;
  - move to MUL (code 7) or DIV (code 8).
REQ-018 MUL: radix-2 shift-add over the magnitudes, one bit per cycle, for exactly WIDTH cycles, then go to FIX.
REQ-019 DIV: restoring division over the magnitudes, one quotient bit per cycle, for exactly WIDTH cycles, then go to FIX.
REQ-020 FIX, one cycle:
  - mult: negate the 2*WIDTH product if sign(a) XOR sign(b);
  - div: negate the quotient if sign(a) XOR sign(b); the remainder takes the sign of op_a;
  - then go to DONE.
REQ-021 DONE: done=1 for one cycle, hi/lo load the final values, then return to IDLE.
REQ-022 Latency: accept at edge k gives busy=1 during cycles k+1 to k+WIDTH+1, and done=1 during cycle k+WIDTH+2 (cycle k+34 for WIDTH=32).
REQ-023 busy SHALL be 1 in states MUL, DIV and FIX, and 0 in IDLE and DONE.
REQ-024 stall SHALL equal busy OR (accept condition), decoded combinationally from start and alu_ctrl so the issuing instruction holds in the same cycle.
REQ-025 hi and lo SHALL change only in DONE and SHALL hold their value until the next DONE.
REQ-026 A new start is accepted no earlier than the cycle after DONE; back-to-back operations therefore have a WIDTH+3 cycle issue interval.
REQ-027 Divide by zero (op_b=0 on a div accept):
  - skip DIV and go to FIX on the next cycle;
  - results: lo = all ones, hi = op_a;
  - div_by_zero = 1 from DONE until the next accept.
REQ-028 Edge values:
  - mult of most-negative by -1 SHALL give the exact 2*WIDTH result;
  - div of most-negative by -1 SHALL give lo = most-negative, hi = 0.
REQ-029 Operand inputs are not required to stay stable after the accept cycle.

Reset
REQ-030 While rst_n=0, regardless of clk:
  - state = IDLE;
  - busy = stall = done = div_by_zero = 0;
  - hi = lo = 0;
  - counter and accumulators = 0.
REQ-031 A reset asserted mid-operation SHALL abort it with no done pulse; the first accept after release SHALL behave normally.

Structure
REQ-032 A shared package SHALL hold:
  - ALU control code constants, including 7 = mult and 8 = div;
  - the FSM state enum typedef.
REQ-033 The restoring-divide step (partial remainder, divisor -> next remainder, quotient bit) SHALL be one sub-module, div_step; the multiply step stays inline.

Verification
REQ-034 mult 7 x -3, WIDTH=32 -> done at cycle k+34, {hi,lo} = 0xFFFFFFFF_FFFFFFEB.
REQ-035 div -7 / 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1), div_by_zero = 0.
REQ-036 div 5 / 0 -> done at k+3, lo = 0xFFFFFFFF, hi = 5, div_by_zero = 1; the flag clears on the next accepted mult.
REQ-037 start with alu_ctrl=2 -> busy, stall and done stay 0; start held high during busy -> exactly one done per accept.
REQ-038 rst_n pulsed low at cycle k+10 of a mult -> all outputs 0 with no done; an accept of 0x80000000 x 0xFFFFFFFF after release -> {hi,lo} = 0x00000000_80000000.
